// File: rtl/cache_pkg.sv
// cache_pkg: shared controller state encoding and width helper for the set-associative cache
package cache_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REFILL = 2'd1, WRITE = 2'd2} state_t;
  function automatic int lg(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cache_lru.sv
// cache_lru: per-set true-LRU ages (age 0 = MRU), update on touch, victim = lowest invalid way else oldest way
module cache_lru
  import cache_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 64,
  localparam int WW = lg(WAYS),
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] idx,
  input  logic [WAYS-1:0]  valid,
  input  logic             touch,
  input  logic [IDX_W-1:0] touch_idx,
  input  logic [WW-1:0]    touch_way,
  output logic [WW-1:0]    victim
);
  if (WAYS == 1) begin : g_one
    assign victim = '0;
  end else begin : g_lru
    logic [WW-1:0] age_q [SETS][WAYS];
    logic found;
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++) age_q[s][w] <= WW'(w);
      end else if (touch) begin
        for (int w = 0; w < WAYS; w++)
          if (WW'(w) == touch_way) age_q[touch_idx][w] <= '0;
          else if (age_q[touch_idx][w] < age_q[touch_idx][touch_way])
            age_q[touch_idx][w] <= age_q[touch_idx][w] + 1'b1;
      end
    end
    always_comb begin
      victim = '0;
      found = 1'b0;
      for (int w = WAYS - 1; w >= 0; w--)
        if (!valid[w]) begin
          victim = WW'(w);
          found = 1'b1;
        end
      if (!found)
        for (int w = 0; w < WAYS; w++)
          if (age_q[idx][w] == WW'(WAYS - 1)) victim = WW'(w);
    end
  end
endmodule

// File: rtl/set_assoc_cache.sv
// set_assoc_cache: N-way write-through no-write-allocate cache, true-LRU, word-serial block refill; CACHE_STATS_EN adds stat_hits/stat_misses
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WAYS = 2,
  parameter int SETS = 64,
  parameter int BLOCK_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
`endif
);
  localparam int BYTE_W = $clog2(DATA_W / 8);
  localparam int WORD_W = $clog2(BLOCK_WORDS);
  localparam int OFF_W = WORD_W + BYTE_W;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int WW = lg(WAYS);
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } meta_t;
  state_t state;
  meta_t meta_q [WAYS][SETS];
  logic [DATA_W-1:0] data_q [WAYS][SETS][BLOCK_WORDS];
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [WORD_W-1:0] cnt, word;
  logic [WW-1:0] victim_q, victim, hit_way, touch_way;
  logic [WAYS-1:0] hit_vec, set_valid;
  logic [IDX_W-1:0] idx, lat_idx, touch_idx;
  logic [TAG_W-1:0] tag, lat_tag;
  logic hit, lookup, touch, last, fill_done;
  assign idx = cpu_addr[OFF_W +: IDX_W];
  assign tag = cpu_addr[ADDR_W-1 -: TAG_W];
  assign word = cpu_addr[BYTE_W +: WORD_W];
  assign lat_idx = lat_addr[OFF_W +: IDX_W];
  assign lat_tag = lat_addr[ADDR_W-1 -: TAG_W];
  always_comb begin
    hit_vec = '0;
    set_valid = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      set_valid[w] = meta_q[w][idx].valid;
      hit_vec[w] = meta_q[w][idx].valid && meta_q[w][idx].tag == tag;
      if (hit_vec[w]) hit_way = hit_way | WW'(w);
    end
  end
  assign hit = |hit_vec;
  assign lookup = state == IDLE && cpu_req;
  assign last = cnt == WORD_W'(BLOCK_WORDS - 1);
  assign fill_done = state == REFILL && mem_ack && last;
  assign touch = (lookup && hit) || fill_done;
  assign touch_idx = state == IDLE ? idx : lat_idx;
  assign touch_way = state == IDLE ? hit_way : victim_q;
  assign cpu_stall = state == REFILL || (state == WRITE && !mem_ack) || (lookup && (cpu_we || !hit));
  assign cpu_rdata = lookup && !cpu_we && hit ? data_q[hit_way][idx][word] : '0;
  assign mem_rd = state == REFILL;
  assign mem_wr = state == WRITE;
  assign mem_addr = state == REFILL ? {lat_addr[ADDR_W-1:OFF_W], OFF_W'(0)} | (ADDR_W'(cnt) << BYTE_W)
                  : state == WRITE ? lat_addr : '0;
  assign mem_wdata = state == WRITE ? lat_wdata : '0;
  cache_lru #(.WAYS(WAYS), .SETS(SETS)) u_lru (
    .clk(clk),
    .rst(rst),
    .idx(idx),
    .valid(set_valid),
    .touch(touch),
    .touch_idx(touch_idx),
    .touch_way(touch_way),
    .victim(victim)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      lat_addr <= '0;
      lat_wdata <= '0;
      victim_q <= '0;
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < SETS; s++) meta_q[w][s].valid <= 1'b0;
    end else begin
      if (lookup && (cpu_we || !hit)) begin
        state <= cpu_we ? WRITE : REFILL;
        lat_addr <= cpu_addr;
        lat_wdata <= cpu_wdata;
        victim_q <= victim;
      end
      if (state == REFILL && mem_ack) cnt <= cnt + 1'b1;
      if (fill_done) begin
        meta_q[victim_q][lat_idx] <= {1'b1, lat_tag};
        state <= IDLE;
      end
      if (state == WRITE && mem_ack) state <= IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == REFILL && mem_ack) data_q[victim_q][lat_idx][cnt] <= mem_rdata;
      if (lookup && cpu_we && hit) data_q[hit_way][idx][word] <= cpu_wdata;
    end
  end
`ifdef CACHE_STATS_EN
  logic replay_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits <= '0;
      stat_misses <= '0;
      replay_q <= 1'b0;
    end else if (fill_done) begin
      replay_q <= 1'b1;
    end else if (lookup) begin
      replay_q <= 1'b0;
      if (!replay_q && hit && stat_hits != '1) stat_hits <= stat_hits + 32'd1;
      if (!replay_q && !hit && stat_misses != '1) stat_misses <= stat_misses + 32'd1;
    end
  end
`endif
  assert property (@(posedge clk) disable iff (rst) lookup |-> $onehot0(hit_vec));
endmodule

// File: tb/tb_set_assoc_cache.sv
// tb_set_assoc_cache: scoreboard bench with recency-list cache model and random-latency word memory
module tb_set_assoc_cache;
  localparam int WAYS = 2;
  logic clk = 1'b0;
  logic rst, cpu_req, cpu_we, cpu_stall, mem_rd, mem_wr, mem_ack;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef CACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif
  typedef struct {
    int kind;
    int addr;
    int data;
  } ev_t;
  ev_t exp_q[$];
  int total = 0, bad = 0;
  int gold [32768];
  int mem_arr [32768];
  int mt [64][WAYS];
  int mn [64];
  int wait_cnt;
  always #5 clk = ~clk;
  set_assoc_cache dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );
  function automatic void push_ev(input int k, input int a, input int d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endfunction
  function automatic bit model_access(input int idx, input int tag, input bit alloc);
    int p;
    bit h;
    p = -1;
    for (int i = 0; i < mn[idx]; i++) if (mt[idx][i] == tag) p = i;
    h = p >= 0;
    if (!h && !alloc) return 1'b0;
    if (!h) begin
      if (mn[idx] < WAYS) mn[idx]++;
      p = mn[idx] - 1;
    end
    for (int i = p; i > 0; i--) mt[idx][i] = mt[idx][i-1];
    mt[idx][0] = tag;
    return h;
  endfunction
  task automatic chkv(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic chk(input int k, input int a, input int d, input string nm);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: unexpected event addr=%h data=%h, expected none", nm, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.addr != a || e.data != d) begin
        bad++;
        $display("FAIL %s: got kind=%0d addr=%h data=%h expected kind=%0d addr=%h data=%h",
                 nm, k, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (mem_rd && mem_ack) chk(0, int'(mem_addr), 0, "mem_rd");
      if (mem_wr && mem_ack) chk(1, int'(mem_addr), int'(mem_wdata), "mem_wr");
      if (cpu_req && !cpu_stall) chk(cpu_we ? 3 : 2, 0, cpu_we ? 0 : int'(cpu_rdata), cpu_we ? "write_retire" : "read_data");
    end
  end
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    wait_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if ((mem_rd || mem_wr) && !rst) begin
        if (wait_cnt == 0) begin
          mem_ack = 1'b1;
          if (mem_rd) mem_rdata = 16'(mem_arr[mem_addr >> 1]);
          else mem_arr[mem_addr >> 1] = int'(mem_wdata);
          wait_cnt = $urandom_range(0, 3);
        end else wait_cnt--;
      end
    end
  end
  task automatic do_req(input bit we, input int addr, input int data);
    int n;
    bit h;
    h = model_access((addr >> 4) & 63, addr >> 10, !we);
    if (we) begin
      push_ev(1, addr, data);
      push_ev(3, 0, 0);
      gold[addr >> 1] = data;
    end else begin
      if (!h) for (int i = 0; i < 8; i++) push_ev(0, (addr & 'hFFF0) + 2 * i, 0);
      push_ev(2, 0, gold[addr >> 1]);
    end
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = 16'(addr);
    cpu_wdata = 16'(data);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cpu_stall && n < 200);
    if (cpu_stall) begin
      total++;
      bad++;
      $display("FAIL req_timeout: addr=%h still stalled after %0d cycles, expected completion", addr, n);
    end
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    for (int i = 0; i < 32768; i++) begin
      gold[i] = (i * 37 + 'h1357) & 'hFFFF;
      mem_arr[i] = gold[i];
    end
    for (int s = 0; s < 64; s++) mn[s] = 0;
    rst = 1'b1;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chkv("reset_stall", int'(cpu_stall), 0);
    chkv("reset_mem_rd", int'(mem_rd), 0);
    chkv("reset_mem_wr", int'(mem_wr), 0);
    chkv("reset_mem_addr", int'(mem_addr), 0);
    chkv("reset_rdata", int'(cpu_rdata), 0);
    @(posedge clk);
    #1;
    do_req(0, 'h1234, 0);
    do_req(0, 'h1234, 0);
    do_req(0, 'h1236, 0);
    do_req(1, 'h2000, 'h5555);
`ifdef CACHE_STATS_EN
    chkv("stat_hits", int'(stat_hits), 2);
    chkv("stat_misses", int'(stat_misses), 2);
`endif
    do_req(0, 'h2000, 0);
    do_req(1, 'h1234, 'hBEEF);
    do_req(0, 'h1234, 0);
    do_req(0, 'h0010, 0);
    do_req(0, 'h0410, 0);
    do_req(0, 'h0010, 0);
    do_req(0, 'h0810, 0);
    do_req(0, 'h0010, 0);
    do_req(0, 'h0410, 0);
    for (int i = 0; i < 3; i++) push_ev(0, 'h3450 + 2 * i, 0);
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 16'h3456;
    n = 0;
    for (int c = 0; c < 100 && n < 3; c++) begin
      @(negedge clk);
      if (mem_rd && mem_ack) n++;
    end
    chkv("abort_ack_count", n, 3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cpu_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int s = 0; s < 64; s++) mn[s] = 0;
    @(negedge clk);
    chkv("abort_mem_rd", int'(mem_rd), 0);
    chkv("abort_stall", int'(cpu_stall), 0);
    @(posedge clk);
    #1;
    do_req(0, 'h3456, 0);
    do_req(0, 'h1234, 0);
    for (int i = 0; i < 250; i++) begin
      int a;
      a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 7) << 1);
      if ($urandom_range(0, 3) == 0) do_req(1, a, $urandom_range(0, 65535));
      else do_req(0, a, 0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    repeat (5) @(posedge clk);
    chkv("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
